// File: rtl/adder128_fault_inject.sv
// adder128_fault_inject
// 128-bit unsigned ripple-carry adder with a registered sum and carry-out.
// Every internal node (generate, propagate, carry-out, sum of each bit) can be
// replaced by a stuck-at constant selected through fault_id. The adder is the
// device under study in fault-sensitivity ranking runs.
//
// fault_id encoding (id in 1..8*WIDTH, otherwise no fault):
//   k     = id - 1
//   stuck = k[0]            value forced onto the node
//   kind  = k[2:1]          0 = g_i, 1 = p_i, 2 = c_{i+1}, 3 = s_i
//   bit   = k[BIT_W+2:3]    bit position i
module adder128_fault_inject #(
  parameter int WIDTH = 128,
  parameter int FID_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [FID_W-1:0] fault_id,
  output logic             out_valid,
  output logic [WIDTH-1:0] f,
  output logic             c_out
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam int NUM_FAULTS = 8 * WIDTH;

  localparam logic [1:0] KIND_G = 2'd0;
  localparam logic [1:0] KIND_P = 2'd1;
  localparam logic [1:0] KIND_C = 2'd2;
  localparam logic [1:0] KIND_S = 2'd3;

  logic [FID_W-1:0] fault_index;
  logic             fault_active;
  logic             stuck;
  logic [1:0]       fault_kind;
  logic [BIT_W-1:0] fault_bit;
  logic [WIDTH-1:0] bit_onehot;

  logic [WIDTH-1:0] mask_g;
  logic [WIDTH-1:0] mask_p;
  logic [WIDTH-1:0] mask_c;
  logic [WIDTH-1:0] mask_s;

  logic [WIDTH-1:0] sum_next;
  logic             carry_next;
  logic             carry;
  logic             g_bit;
  logic             p_bit;
  logic             c_bit;
  logic             s_bit;

  // The top bits of the decoded index are only relevant to the range check.
  logic unused_index_bits;

  // Decode fault_id into a single node selection; out-of-range ids leave
  // every mask clear so the adder runs fault-free.
  always_comb begin
    fault_index  = fault_id - {{(FID_W-1){1'b0}}, 1'b1};
    fault_active = (fault_id != '0) && (fault_id <= FID_W'(NUM_FAULTS));
    stuck        = fault_index[0];
    fault_kind   = fault_index[2:1];
    fault_bit    = fault_index[BIT_W+2:3];
    bit_onehot   = {{(WIDTH-1){1'b0}}, 1'b1} << fault_bit;

    mask_g = '0;
    mask_p = '0;
    mask_c = '0;
    mask_s = '0;
    if (fault_active) begin
      case (fault_kind)
        KIND_G:  mask_g = bit_onehot;
        KIND_P:  mask_p = bit_onehot;
        KIND_C:  mask_c = bit_onehot;
        KIND_S:  mask_s = bit_onehot;
        default: mask_g = '0;
      endcase
    end
  end

  assign unused_index_bits = &{1'b0, fault_index[FID_W-1:BIT_W+3]};

  // Ripple the carry from bit 0 upward; each node is overridden at its own
  // driver, so a forced value is what every downstream gate consumes.
  always_comb begin
    sum_next   = '0;
    carry      = 1'b0;
    g_bit      = 1'b0;
    p_bit      = 1'b0;
    c_bit      = 1'b0;
    s_bit      = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      g_bit       = mask_g[i] ? stuck : (a[i] & b[i]);
      p_bit       = mask_p[i] ? stuck : (a[i] ^ b[i]);
      c_bit       = mask_c[i] ? stuck : (g_bit | (p_bit & carry));
      s_bit       = mask_s[i] ? stuck : (p_bit ^ carry);
      sum_next[i] = s_bit;
      carry       = c_bit;
    end
    carry_next = carry;
  end

  // Capture the sum every cycle; out_valid marks which captures carry real
  // operands, and reset discards whatever was in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      f         <= '0;
      c_out     <= 1'b0;
    end else begin
      out_valid <= in_valid;
      f         <= sum_next;
      c_out     <= carry_next;
    end
  end

endmodule

// File: tb/tb_adder128_fault_inject.sv
// tb_adder128_fault_inject
// Directed vectors with hand-derived expectations are pushed into a scoreboard
// queue as they are driven; an independent monitor pops one entry per valid
// output and compares sum and carry-out.
module tb_adder128_fault_inject;

  localparam logic [127:0] ALL_ONES = {128{1'b1}};

  typedef struct {
    logic [127:0] f;
    logic         c;
    string        name;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [127:0] a;
  logic [127:0] b;
  logic [10:0]  fault_id;
  logic         out_valid;
  logic [127:0] f;
  logic         c_out;

  exp_t sb[$];
  int   checks;
  int   failures;

  adder128_fault_inject dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .fault_id  (fault_id),
    .out_valid (out_valid),
    .f         (f),
    .c_out     (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [127:0] op_a,
                               input logic [127:0] op_b, input logic [10:0] fid,
                               input logic [127:0] exp_f, input logic exp_c,
                               input string name);
    exp_t e;
    @(negedge clk);
    #1;
    in_valid = v;
    a        = op_a;
    b        = op_b;
    fault_id = fid;
    if (v) begin
      e.f    = exp_f;
      e.c    = exp_c;
      e.name = name;
      sb.push_back(e);
    end
  endtask

  // Monitor: every valid output must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_output: got f=%h c_out=%b expected no output", f, c_out);
      end else begin
        e = sb.pop_front();
        checkOutput({e.name, "_f"}, f, e.f);
        checkOutput({e.name, "_cout"}, {127'd0, c_out}, {127'd0, e.c});
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] pa;
    logic [127:0] pb;
    logic [128:0] psum;
    int           waited;

    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    fault_id = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", {127'd0, out_valid}, 128'd0);
    checkOutput("reset_f", f, 128'd0);
    checkOutput("reset_cout", {127'd0, c_out}, 128'd0);
    #1;
    rst = 1'b0;

    // Fault-free sums, including the wrap-around carry cases.
    applyStimulus(1'b1, ALL_ONES, 128'd1, 11'd0, 128'd0, 1'b1, "ff_max_plus_1");
    applyStimulus(1'b1, 128'd1, ALL_ONES, 11'd0, 128'd0, 1'b1, "ff_1_plus_max");
    applyStimulus(1'b1, 128'd0, 128'd0, 11'd0, 128'd0, 1'b0, "ff_zero");
    pa   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    pb   = 128'hF0F0_F0F0_0F0F_0F0F_1234_5678_9ABC_DEF0;
    psum = {1'b0, pa} + {1'b0, pb};
    applyStimulus(1'b1, pa, pb, 11'd0, psum[127:0], psum[128], "ff_pattern");
    // An idle cycle must not produce an output.
    applyStimulus(1'b0, ALL_ONES, ALL_ONES, 11'd0, 128'd0, 1'b0, "idle");

    // c1 stuck-at-0 blocks the carry out of bit 0.
    applyStimulus(1'b1, ALL_ONES, 128'd1, 11'd5, {ALL_ONES[127:1], 1'b0}, 1'b0, "c1_sa0");
    // s127 stuck-at-1 (the highest fault id).
    applyStimulus(1'b1, 128'd0, 128'd0, 11'd1024, {1'b1, 127'd0}, 1'b0, "s127_sa1");
    // Just past the fault range and further out: both fault-free.
    applyStimulus(1'b1, 128'd0, 128'd0, 11'd1025, 128'd0, 1'b0, "id1025_none");
    applyStimulus(1'b1, 128'd0, 128'd0, 11'd1026, 128'd0, 1'b0, "id1026_none");
    // g0 stuck-at-1: c1=1 gives s1=1, but p1=0 stops the carry there.
    applyStimulus(1'b1, 128'd0, 128'd0, 11'd2, 128'd2, 1'b0, "g0_sa1");
    // p0 stuck-at-1 flips s0 only.
    applyStimulus(1'b1, 128'd0, 128'd0, 11'd4, 128'd1, 1'b0, "p0_sa1");
    // c2 stuck-at-1 sets s2.
    applyStimulus(1'b1, 128'd0, 128'd0, 11'd14, 128'd4, 1'b0, "c2_sa1");
    // s0 stuck-at-0 masks a 1+0 sum.
    applyStimulus(1'b1, 128'd1, 128'd0, 11'd7, 128'd0, 1'b0, "s0_sa0");
    // c128 stuck-at-0 hides the overflow; stuck-at-1 invents one.
    applyStimulus(1'b1, ALL_ONES, 128'd1, 11'd1021, 128'd0, 1'b0, "c128_sa0");
    applyStimulus(1'b1, 128'd0, 128'd0, 11'd1022, 128'd0, 1'b1, "c128_sa1");

    // Reset while a valid max+1 is being presented: it must be discarded.
    @(negedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = ALL_ONES;
    b        = 128'd1;
    fault_id = 11'd0;
    @(negedge clk);
    checkOutput("midrst_out_valid", {127'd0, out_valid}, 128'd0);
    checkOutput("midrst_f", f, 128'd0);
    checkOutput("midrst_cout", {127'd0, c_out}, 128'd0);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    applyStimulus(1'b1, 128'd0, 128'd0, 11'd0, 128'd0, 1'b0, "post_rst_zero");
    applyStimulus(1'b0, 128'd0, 128'd0, 11'd0, 128'd0, 1'b0, "drain");

    // Let the scoreboard drain within a bounded number of cycles.
    waited = 0;
    while (sb.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    #1;
    checkOutput("scoreboard_drained", 128'(sb.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
